// File: rtl/pipeline_credit_buffer.sv
// pipeline_credit_buffer
// Credit-managed landing buffer at the end of a fixed-latency upstream
// pipeline. A word may only be launched (issue_grant) while a buffer slot is
// guaranteed for it, counting both stored words and words still travelling
// through the upstream delay line. The buffer is a first-word-fall-through
// FIFO with a flush/drain FSM and a sticky overflow flag.
//
// Optional feature: define PIPELINE_CREDIT_BYPASS_EN to forward an arriving
// word straight to data_out in the same cycle when the buffer is empty.
//
// Handshake: a word moves across data_out when data_out_valid and
// data_out_ready are both high at a rising clk edge; data_out_valid never
// depends on data_out_ready. A launch happens when issue_grant is high.

module pipeline_credit_buffer #(
    parameter int NUM_BITS = 16,
    parameter int DEPTH    = 4,
    parameter int LATENCY  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_req,
    output logic                issue_grant,
    input  logic                data_in_valid,
    input  logic [NUM_BITS-1:0] data_in,
    output logic                data_out_valid,
    output logic [NUM_BITS-1:0] data_out,
    input  logic                data_out_ready,
    input  logic                flush,
    output logic [6:0]          credit_count,
    output logic                overflow_err,
    output logic                dbg_drain
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [6:0]       DEPTH_C  = 7'(DEPTH);

    // Reject parameter values the counters and pointers are not sized for.
    if (DEPTH < 2 || DEPTH > 64 || LATENCY < 0 || LATENCY > 16) begin : g_bad_params
        $error("pipeline_credit_buffer: DEPTH must be 2..64 and LATENCY 0..16");
    end

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           occ_q, occ_d;
    logic [6:0]           inflight_q, inflight_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;
    logic [NUM_BITS-1:0]  mem_q [DEPTH];

    logic running;
    logic buf_empty;
    logic buf_full;
    logic bypass_hit;
    logic push;
    logic pop;
    logic wr_en;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Output and handshake decode from the registered counters.
    always_comb begin
        running   = (state_q == RUN);
        buf_empty = (occ_q == '0);
        buf_full  = (occ_q == DEPTH_C);
`ifdef PIPELINE_CREDIT_BYPASS_EN
        bypass_hit = buf_empty & data_in_valid & running;
`else
        bypass_hit = 1'b0;
`endif
        credit_count   = DEPTH_C - occ_q - inflight_q;
        issue_grant    = issue_req & (credit_count != '0) & running;
        data_out_valid = ~buf_empty | bypass_hit;
        data_out       = bypass_hit ? data_in : mem_q[rd_ptr_q];
        pop            = ~buf_empty & data_out_ready;
        // A bypassed word that the consumer takes immediately is never stored.
        push           = data_in_valid & running & ~(bypass_hit & data_out_ready);
        wr_en          = push & (~buf_full | pop);
        overflow_err   = ovf_q;
        dbg_drain      = (state_q == DRAIN);
    end

    // Next-state for counters, pointers, overflow flag and the RUN/DRAIN FSM.
    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;

        case ({wr_en, pop})
            2'b10:   occ_d = occ_q + 7'd1;
            2'b01:   occ_d = occ_q - 7'd1;
            default: occ_d = occ_q;
        endcase
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push & buf_full & ~pop) begin
            ovf_d = 1'b1;
        end

        // Arrivals with nothing in flight (e.g. launched before a reset) do
        // not underflow the counter.
        if (issue_grant & ~data_in_valid) begin
            inflight_d = inflight_q + 7'd1;
        end else if (~issue_grant & data_in_valid & (inflight_q != '0)) begin
            inflight_d = inflight_q - 7'd1;
        end

        case (state_q)
            RUN: begin
                if (flush && (inflight_q != '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!flush && (inflight_q == '0)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Flush discards everything stored, overriding this cycle's push/pop.
        if (flush) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // State registers; reset wins over flush and every handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            occ_q      <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_pipeline_credit_buffer.sv
// Testbench for pipeline_credit_buffer (DEPTH=4, LATENCY=3, 16-bit words).
// The bench plays the upstream delay line: every grant launches the next word
// number, which arrives on data_in LATENCY cycles later. A queue-based model
// tracks buffer contents, in-flight count, drain mode and the overflow flag.

`timescale 1ns/1ps

module tb_pipeline_credit_buffer;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    // Clock / reset and DUT connections
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         issue_req = 1'b0;
    logic         issue_grant;
    logic         data_in_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_out_valid;
    logic [W-1:0] data_out;
    logic         data_out_ready = 1'b0;
    logic         flush = 1'b0;
    logic [6:0]   credit_count;
    logic         overflow_err;
    logic         dbg_drain;

    pipeline_credit_buffer #(
        .NUM_BITS (W),
        .DEPTH    (DEPTH),
        .LATENCY  (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_req      (issue_req),
        .issue_grant    (issue_grant),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .data_out_ready (data_out_ready),
        .flush          (flush),
        .credit_count   (credit_count),
        .overflow_err   (overflow_err),
        .dbg_drain      (dbg_drain)
    );

    always #5 clk = ~clk;

    // Counters
    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Stimulus controls
    logic         req_i = 1'b0;
    logic         ready_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         force_dv = 1'b0;
    logic [W-1:0] force_data = '0;

    // Reference model
    logic [W-1:0] exp_q[$];
    int           m_inflight = 0;
    bit           m_drain = 1'b0;
    bit           m_ovf = 1'b0;
    int           next_word = 1;
    int           arr_cyc[$];
    logic [W-1:0] arr_dat[$];

    // Per-cycle expectations and samples
    bit           exp_grant;
    bit           exp_valid;
    int           exp_credit;
    logic [W-1:0] exp_dout;
    logic         obs_grant;
    logic         obs_valid;
    logic         obs_ovf;
    logic         obs_drain;
    logic [W-1:0] obs_dout;
    logic [6:0]   obs_credit;

    // One clock cycle: drive, sample, scoreboard against the model, advance.
    task automatic cycle();
        logic         dv;
        logic [W-1:0] din;
        bit           byp;
        bit           pop;
        bit           took;
        int           infl0;
        dv  = 1'b0;
        din = W'($urandom);
        if (arr_cyc.size() != 0 && arr_cyc[0] == cyc) begin
            dv  = 1'b1;
            din = arr_dat[0];
            void'(arr_cyc.pop_front());
            void'(arr_dat.pop_front());
        end
        if (force_dv) begin
            dv  = 1'b1;
            din = force_data;
        end
        rst_n          = rst_i;
        issue_req      = req_i;
        data_in_valid  = dv;
        data_in        = din;
        data_out_ready = ready_i;
        flush          = flush_i;

        exp_credit = DEPTH - exp_q.size() - m_inflight;
        exp_grant  = req_i && (exp_credit != 0) && !m_drain;
        byp        = 1'b0;
`ifdef PIPELINE_CREDIT_BYPASS_EN
        byp = (exp_q.size() == 0) && dv && !m_drain;
`endif
        exp_valid = (exp_q.size() != 0) || byp;
        exp_dout  = (exp_q.size() != 0) ? exp_q[0] : din;

        #1;
        obs_grant  = issue_grant;
        obs_valid  = data_out_valid;
        obs_dout   = data_out;
        obs_credit = credit_count;
        obs_ovf    = overflow_err;
        obs_drain  = dbg_drain;

        if (rst_i) begin
            n_vec++;
            if (obs_grant !== exp_grant) begin
                n_fail++;
                $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, obs_grant, exp_grant);
            end
            n_vec++;
            if (obs_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL data_out_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid);
            end
            if (exp_valid) begin
                n_vec++;
                if (obs_dout !== exp_dout) begin
                    n_fail++;
                    $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, obs_dout, exp_dout);
                end
            end
            n_vec++;
            if (obs_credit !== 7'(exp_credit)) begin
                n_fail++;
                $display("FAIL credit_count cyc=%0d got=%0d exp=%0d", cyc, obs_credit, exp_credit);
            end
            n_vec++;
            if (obs_ovf !== m_ovf) begin
                n_fail++;
                $display("FAIL overflow_err cyc=%0d got=%b exp=%b", cyc, obs_ovf, m_ovf);
            end
            n_vec++;
            if (obs_drain !== m_drain) begin
                n_fail++;
                $display("FAIL drain_state cyc=%0d got=%b exp=%b", cyc, obs_drain, m_drain);
            end
        end

        if (!rst_i) begin
            exp_q.delete();
            m_inflight = 0;
            m_drain    = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            infl0 = m_inflight;
            pop   = (exp_q.size() != 0) && ready_i;
            took  = byp && ready_i;
            if (pop) void'(exp_q.pop_front());
            if (dv && !m_drain && !took) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(din);
                else m_ovf = 1'b1;
            end
            if (exp_grant) begin
                arr_cyc.push_back(cyc + LAT);
                arr_dat.push_back(W'(next_word));
                next_word++;
                m_inflight++;
            end
            if (dv && m_inflight > 0) m_inflight--;
            if (m_drain) begin
                if (!flush_i && infl0 == 0) m_drain = 1'b0;
            end else if (flush_i && infl0 != 0) begin
                m_drain = 1'b1;
            end
            if (flush_i) exp_q.delete();
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; req_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; force_dv = 1'b0;
        repeat (2) cycle();
        rst_i = 1'b1;
        rst_n = 1'b1;
        issue_req = 1'b0;
        #1;
        n_vec++;
        if (credit_count !== 7'(DEPTH)) begin
            n_fail++; $display("FAIL reset_credit got=%0d exp=%0d", credit_count, DEPTH);
        end
        n_vec++;
        if (data_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=0", data_out_valid);
        end
        n_vec++;
        if (overflow_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow_err);
        end
        n_vec++;
        if (issue_grant !== 1'b0) begin
            n_fail++; $display("FAIL reset_grant_idle got=%b exp=0", issue_grant);
        end
        issue_req = 1'b1;
        #1;
        n_vec++;
        if (issue_grant !== 1'b1) begin
            n_fail++; $display("FAIL reset_grant_req got=%b exp=1", issue_grant);
        end
        issue_req = 1'b0;
    endtask

    task automatic test_fill();
        int grants;
        int seq[5] = '{4, 3, 2, 1, 0};
        grants = 0;
        req_i = 1'b1; ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            grants += int'(obs_grant);
            if (i < 5) begin
                n_vec++;
                if (obs_credit !== 7'(seq[i])) begin
                    n_fail++; $display("FAIL fill_credit_seq i=%0d got=%0d exp=%0d", i, obs_credit, seq[i]);
                end
            end
        end
        req_i = 1'b0;
        n_vec++;
        if (grants != 4) begin
            n_fail++; $display("FAIL fill_grants got=%0d exp=4", grants);
        end
        n_vec++;
        if (obs_valid !== 1'b1 || obs_dout !== 16'h0001 || obs_credit !== 7'd0 || obs_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_final got=v%b d%h c%0d o%b exp=v1 d0001 c0 o0",
                     obs_valid, obs_dout, obs_credit, obs_ovf);
        end
    endtask

    task automatic test_overflow();
        req_i = 1'b0; ready_i = 1'b0;
        force_dv = 1'b1; force_data = 16'hDEAD;
        cycle();
        force_dv = 1'b0;
        repeat (3) cycle();
        n_vec++;
        if (obs_ovf !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky got=%b exp=1", obs_ovf);
        end
        n_vec++;
        if (obs_dout !== 16'h0001 || obs_credit !== 7'd0) begin
            n_fail++; $display("FAIL overflow_head got=d%h c%0d exp=d0001 c0", obs_dout, obs_credit);
        end
    endtask

    task automatic test_pop_one();
        req_i = 1'b1; ready_i = 1'b1;
        cycle();
        n_vec++;
        if (obs_grant !== 1'b0 || obs_dout !== 16'h0001) begin
            n_fail++; $display("FAIL pop_cycle got=g%b d%h exp=g0 d0001", obs_grant, obs_dout);
        end
        ready_i = 1'b0;
        cycle();
        n_vec++;
        if (obs_credit !== 7'd1 || obs_grant !== 1'b1) begin
            n_fail++; $display("FAIL pop_regrant got=c%0d g%b exp=c1 g1", obs_credit, obs_grant);
        end
        repeat (3) cycle();
        req_i = 1'b0;
        n_vec++;
        if (obs_credit !== 7'd0 || obs_dout !== 16'h0002) begin
            n_fail++; $display("FAIL pop_refill got=c%0d d%h exp=c0 d0002", obs_credit, obs_dout);
        end
    endtask

    task automatic test_reset_mid();
        req_i = 1'b1; ready_i = 1'b1;
        cycle();
        ready_i = 1'b0;
        cycle();
        req_i = 1'b0; rst_i = 1'b0;
        cycle();
        rst_i = 1'b1;
        cycle();
        n_vec++;
        if (obs_valid !== 1'b0 || obs_credit !== 7'(DEPTH) || obs_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got=v%b c%0d o%b exp=v0 c%0d o0", obs_valid, obs_credit, obs_ovf, DEPTH);
        end
        cycle();
        ready_i = 1'b1;
        cycle();
        n_vec++;
        if (obs_valid !== 1'b1 || obs_dout !== 16'h0006) begin
            n_fail++; $display("FAIL reset_late_word got=v%b d%h exp=v1 d0006", obs_valid, obs_dout);
        end
        cycle();
        ready_i = 1'b0;
    endtask

    task automatic test_flush();
        int grants;
        req_i = 1'b1;
        cycle();
        req_i = 1'b0;
        repeat (3) cycle();
        grants = 0;
        req_i = 1'b1;
        repeat (2) begin
            cycle();
            grants += int'(obs_grant);
        end
        n_vec++;
        if (grants != 2) begin
            n_fail++; $display("FAIL flush_setup_grants got=%0d exp=2", grants);
        end
        req_i = 1'b0; flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        n_vec++;
        if (obs_valid !== 1'b1 || obs_dout !== 16'h0007) begin
            n_fail++; $display("FAIL flush_stored got=v%b d%h exp=v1 d0007", obs_valid, obs_dout);
        end
        grants = 0;
        req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            grants += int'(obs_grant);
            n_vec++;
            if (obs_drain !== 1'b1) begin
                n_fail++; $display("FAIL flush_in_drain i=%0d got=%b exp=1", i, obs_drain);
            end
        end
        n_vec++;
        if (grants != 0) begin
            n_fail++; $display("FAIL flush_drain_grants got=%0d exp=0", grants);
        end
        req_i = 1'b0;
        cycle();
        n_vec++;
        if (obs_drain !== 1'b0 || obs_credit !== 7'(DEPTH) || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_recover got=s%b c%0d v%b exp=s0 c%0d v0", obs_drain, obs_credit, obs_valid, DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        int grants;
        int pops;
        grants = 0; pops = 0;
        req_i = 1'b1; ready_i = 1'b1;
        repeat (40) begin
            cycle();
            grants += int'(obs_grant);
            pops   += int'(obs_valid & ready_i);
        end
        req_i = 1'b0;
        repeat (8) begin
            cycle();
            pops += int'(obs_valid & ready_i);
        end
        n_vec++;
        if (pops != grants || grants == 0) begin
            n_fail++; $display("FAIL b2b_conservation got=pops%0d exp=grants%0d", pops, grants);
        end
        n_vec++;
        if (obs_credit !== 7'(DEPTH)) begin
            n_fail++; $display("FAIL b2b_idle_credit got=%0d exp=%0d", obs_credit, DEPTH);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            req_i   = ($urandom_range(0, 9) < 7);
            ready_i = $urandom_range(0, 1);
            flush_i = ($urandom_range(0, 49) == 0);
            cycle();
        end
        req_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        repeat (12) cycle();
        n_vec++;
        if (obs_credit !== 7'(DEPTH) || obs_valid !== 1'b0 || obs_drain !== 1'b0) begin
            n_fail++;
            $display("FAIL random_quiesce got=c%0d v%b s%b exp=c%0d v0 s0", obs_credit, obs_valid, obs_drain, DEPTH);
        end
        ready_i = 1'b0;
    endtask

`ifdef PIPELINE_CREDIT_BYPASS_EN
    task automatic test_bypass();
        req_i = 1'b0; ready_i = 1'b1;
        force_dv = 1'b1; force_data = 16'hABCD;
        cycle();
        force_dv = 1'b0;
        n_vec++;
        if (obs_valid !== 1'b1 || obs_dout !== 16'hABCD) begin
            n_fail++; $display("FAIL bypass_same_cycle got=v%b d%h exp=v1 dabcd", obs_valid, obs_dout);
        end
        cycle();
        n_vec++;
        if (obs_valid !== 1'b0 || obs_credit !== 7'(DEPTH)) begin
            n_fail++; $display("FAIL bypass_not_stored got=v%b c%0d exp=v0 c%0d", obs_valid, obs_credit, DEPTH);
        end
        ready_i = 1'b0;
    endtask
`endif

    // Watchdog so the run always ends with a summary.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_pop_one();
        test_reset_mid();
        test_flush();
        test_back_to_back();
        test_random();
`ifdef PIPELINE_CREDIT_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_credit_buffer.md
PIPELINE_CREDIT_BUFFER -- requirements
Module: pipeline_credit_buffer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16, data width.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries (2..64, not necessarily a power of 2).
REQ-003 SHALL have parameter LATENCY, default 1, cycles from issue_grant to data_in_valid in the upstream delay line (0..16).
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk (in, 1, rising edge) and rst_n (in, 1, sync active-low).
REQ-005 SHALL have issue_req (in, 1): producer requests launch of one word into the upstream pipeline.
REQ-006 SHALL have issue_grant (out, 1): launch accepted this cycle; combinational.
REQ-007 SHALL have data_in_valid (in, 1) and data_in (in, NUM_BITS): word arriving from the delay line.
REQ-008 SHALL have data_out_valid (out, 1), data_out (out, NUM_BITS) and data_out_ready (in, 1): consumer valid/ready handshake.
REQ-009 SHALL have flush (in, 1): discard all buffered and in-flight words.
REQ-010 SHALL have credit_count (out, 7): free credits.
REQ-011 SHALL have overflow_err (out, 1): sticky; set on a write to a full buffer.

Function
REQ-012 SHALL compute credit_count = DEPTH - occupancy - inflight, all registered counters.
REQ-013 SHALL assert issue_grant = issue_req & (credit_count != 0) & (state == RUN).
REQ-014 SHALL increment inflight on issue_grant, decrement it on data_in_valid, and leave it unchanged when both occur.
REQ-015 SHALL write data_in at wr_ptr when data_in_valid is high in state RUN.
REQ-016 SHALL pop on data_out_valid & data_out_ready, advancing rd_ptr.
REQ-017 SHALL present the head entry first-word-fall-through: data_out = mem[rd_ptr], data_out_valid = (occupancy != 0).
REQ-018 SHALL drive data_out to the unchanged mem[rd_ptr] when empty; only data_out_valid qualifies it.
REQ-019 SHALL wrap pointers from DEPTH-1 to 0 explicitly.
REQ-020 SHALL have write-to-data_out_valid latency of 1 cycle.
REQ-021 SHALL accept a simultaneous push and pop when full: occupancy unchanged, no overflow.
REQ-022 SHALL, on a push while full without a pop, drop the word, set overflow_err, and leave occupancy unchanged.
REQ-023 SHALL, on a pop while empty, take no action (not reachable, since data_out_valid is 0).
REQ-024 SHALL implement FSM states RUN and DRAIN.
REQ-025 SHALL transition RUN->DRAIN on flush and DRAIN->RUN when inflight == 0 and flush is low.
REQ-026 SHALL, on flush, clear occupancy and pointers next cycle; DRAIN discards data_in_valid words (inflight still decrements) and forces issue_grant = 0.
REQ-027 SHALL, on flush with inflight == 0, clear the buffer and stay in RUN.
REQ-028 SHALL remain in DRAIN while flush is held.
REQ-029 SHALL never let credit_count exceed DEPTH nor go below 0 under legal stimulus.

Reset
REQ-030 SHALL, with rst_n low at a clk edge, set state = RUN; occupancy, inflight and pointers = 0; overflow_err = 0.
REQ-031 SHALL hold outputs after reset at: credit_count = DEPTH; data_out_valid = 0; issue_grant = 0 unless issue_req.
REQ-032 SHALL, on reset mid-operation, abandon all buffered and in-flight words; words arriving afterwards count as overflow only if the buffer is full.
REQ-033 SHALL give rst_n priority over flush and all handshakes.
REQ-034 SHALL not reset memory contents.

Configuration
REQ-035 SHALL, when PIPELINE_CREDIT_BYPASS_EN is defined, forward data_in to data_out in the same cycle when empty & data_in_valid & state == RUN (data_out_valid = 1); the word SHALL not be stored if data_out_ready is high, and SHALL be stored normally otherwise.
REQ-036 SHALL, when PIPELINE_CREDIT_BYPASS_EN is undefined, add no bypass path and keep latency fixed at 1 cycle (REQ-020).

Verification
REQ-037 SHALL cover: DEPTH=4, LATENCY=3, issue_req held, data_out_ready=0 -> exactly 4 grants, credit_count 4,3,2,1,0, occupancy reaches 4, no overflow_err.
REQ-038 SHALL cover: from full, data_out_ready=1 for 1 cycle -> pop of 0x0001, credit_count 0->1, one new grant, its word 0x0005 lands 3 cycles later.
REQ-039 SHALL cover: forced data_in_valid with 4 stored and no pop -> overflow_err=1 and sticky, occupancy 4, head still 0x0001.
REQ-040 SHALL cover: 2 words in flight, 1 stored, flush pulse -> state DRAIN, no grants, both arrivals dropped, RUN after inflight=0, credit_count=4.
REQ-041 SHALL cover: rst_n low mid-burst with 3 stored -> next cycle data_out_valid=0, credit_count=4, overflow_err=0.
REQ-042 SHALL cover: PIPELINE_CREDIT_BYPASS_EN defined, empty, data_in=0xABCD, valid, ready=1 -> data_out=0xABCD, data_out_valid=1 same cycle, occupancy stays 0.
